spy_path_delay_meter: RTL and testbench

- Measurement end of a chained spy path: launches transitions into the chain's pathInput and times their arrival at the chain's pathResult in reference-clock cycles.
- Takes 2^SAMPLES_LOG samples with alternating edge polarity, accumulates them, and reports total, average and timeout status.
- Sits between the chain instance and the readout/control logic.

---
 rtl/spy_path_delay_meter.sv | 180 ++++++++++++++++++
 tb/tb_spy_path_delay_meter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spy_path_delay_meter.sv
// Spy path delay meter: launches alternating edges into a chain and times their return in clk cycles.
// Latency: per sample SYNC_STAGES+1+chain delay cycles plus one launch cycle; done pulses one cycle after the last sample.
// Backpressure: none; start is ignored while busy. Optional macro SPY_DELAY_MINMAX_EN adds minLat/maxLat outputs.
module spy_path_delay_meter #(
    parameter int LAT_W        = 8,
    parameter int SAMPLES_LOG  = 3,
    parameter int SYNC_STAGES  = 2,
    parameter int PATH_INVERTS = 0
) (
    input  logic                         clk,
    input  logic                         rstN,
    input  logic                         start,
    output logic                         pathInput,
    input  logic                         pathResult,
    output logic                         busy,
    output logic                         done,
    output logic                         timeout,
    output logic [LAT_W+SAMPLES_LOG-1:0] total,
    output logic [LAT_W-1:0]             average
`ifdef SPY_DELAY_MINMAX_EN
    ,
    output logic [LAT_W-1:0]             minLat,
    output logic [LAT_W-1:0]             maxLat
`endif
);

    localparam int                   TW       = LAT_W + SAMPLES_LOG;
    localparam int                   NSAMP    = 1 << SAMPLES_LOG;
    localparam logic                 INV      = (PATH_INVERTS != 0);
    // Last counter value before the per-phase timeout limit (all-ones) is reached.
    localparam logic [LAT_W-1:0]     LAT_LAST = {{(LAT_W-1){1'b1}}, 1'b0};
    localparam logic [SAMPLES_LOG:0] IDX_LAST = (SAMPLES_LOG+1)'(NSAMP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_LAUNCH,
        S_WAIT,
        S_FINISH
    } state_t;

    state_t                 state_q, state_d;
    logic [LAT_W-1:0]       lat_q, lat_d;
    logic [SAMPLES_LOG:0]   idx_q, idx_d;
    logic                   pin_q, pin_d;
    logic [TW-1:0]          tot_q, tot_d;
    logic [LAT_W-1:0]       avg_q, avg_d;
    logic                   to_q, to_d;
    logic [SYNC_STAGES-1:0] sync_q;
`ifdef SPY_DELAY_MINMAX_EN
    logic [LAT_W-1:0]       min_q, min_d;
    logic [LAT_W-1:0]       max_q, max_d;
`endif

    logic                   match_w;
    logic [LAT_W-1:0]       sample_w;
    logic [TW:0]            sum_w;

    // The chain settles to pathInput (or its inverse) once the launched edge has fully propagated.
    assign match_w  = (sync_q[SYNC_STAGES-1] == (pin_q ^ INV));
    // The match cycle itself is counted, so a sample is one more than the cycles already waited.
    assign sample_w = lat_q + 1'b1;
    assign sum_w    = {1'b0, tot_q} + {{(SAMPLES_LOG+1){1'b0}}, sample_w};

    assign pathInput = pin_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FINISH);
    assign timeout   = to_q;
    assign total     = tot_q;
    assign average   = avg_q;
`ifdef SPY_DELAY_MINMAX_EN
    assign minLat    = min_q;
    assign maxLat    = max_q;
`endif

    // Synchronizer for the asynchronous chain output, plus all measurement state registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sync_q  <= '0;
            state_q <= S_IDLE;
            lat_q   <= '0;
            idx_q   <= '0;
            pin_q   <= 1'b0;
            tot_q   <= '0;
            avg_q   <= '0;
            to_q    <= 1'b0;
`ifdef SPY_DELAY_MINMAX_EN
            min_q   <= '1;
            max_q   <= '0;
`endif
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pathResult};
            state_q <= state_d;
            lat_q   <= lat_d;
            idx_q   <= idx_d;
            pin_q   <= pin_d;
            tot_q   <= tot_d;
            avg_q   <= avg_d;
            to_q    <= to_d;
`ifdef SPY_DELAY_MINMAX_EN
            min_q   <= min_d;
            max_q   <= max_d;
`endif
        end
    end

    // Next-state logic: prime until settled, then launch/wait for each sample, then report.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        idx_d   = idx_q;
        pin_d   = pin_q;
        tot_d   = tot_q;
        avg_d   = avg_q;
        to_d    = to_q;
`ifdef SPY_DELAY_MINMAX_EN
        min_d   = min_q;
        max_d   = max_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    tot_d   = '0;
                    avg_d   = '0;
                    to_d    = 1'b0;
                    lat_d   = '0;
                    idx_d   = '0;
`ifdef SPY_DELAY_MINMAX_EN
                    min_d   = '1;
                    max_d   = '0;
`endif
                    state_d = S_PRIME;
                end
            end
            S_PRIME: begin
                if (match_w) begin
                    lat_d   = '0;
                    state_d = S_LAUNCH;
                end else if (lat_q == LAT_LAST) begin
                    to_d    = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    lat_d   = lat_q + 1'b1;
                end
            end
            S_LAUNCH: begin
                pin_d   = ~pin_q;
                lat_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (match_w) begin
                    tot_d = sum_w[TW] ? {TW{1'b1}} : sum_w[TW-1:0];
`ifdef SPY_DELAY_MINMAX_EN
                    if (sample_w < min_q) min_d = sample_w;
                    if (sample_w > max_q) max_d = sample_w;
`endif
                    idx_d   = idx_q + 1'b1;
                    state_d = (idx_q == IDX_LAST) ? S_FINISH : S_LAUNCH;
                end else if (lat_q == LAT_LAST) begin
                    to_d    = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    lat_d   = lat_q + 1'b1;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Average is loaded with the final (possibly partial) total so it is valid while done is high.
        if (state_d == S_FINISH) begin
            avg_d = tot_d[TW-1:SAMPLES_LOG];
        end
    end

endmodule

// File: tb/tb_spy_path_delay_meter.sv
module tb_spy_path_delay_meter;

    localparam int SYNC = 2;

    logic        clk;
    logic        rstN;
    logic        start;
    logic        pathInput;
    logic        pathResult;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [10:0] total;
    logic [7:0]  average;

    logic        start_inv;
    logic        pin_inv;
    logic        res_inv;
    logic        busy_inv;
    logic        done_inv;
    logic        to_inv;
    logic [10:0] tot_inv;
    logic [7:0]  avg_inv;
`ifdef SPY_DELAY_MINMAX_EN
    logic [7:0]  min_lat, max_lat, min_inv, max_inv;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    // Chain model: a level change on pathInput appears on pathResult after a polarity-dependent delay.
    int   d_rise = 0;
    int   d_fall = 0;
    bit   stuck0 = 1'b0;
    int   chg_cnt = 100000;
    logic last_pi = 1'b0;

    int   cyc = 0;
    int   tog_cnt = 0;
    int   last_tog_t = 0;
    int   tog_gap = 0;
    logic mon_pi = 1'b0;
    int   done_cnt = 0;

    assign pathResult = stuck0 ? 1'b0 :
                        ((chg_cnt >= (pathInput ? d_rise : d_fall)) ? pathInput : ~pathInput);
    assign res_inv    = ~pin_inv;

    spy_path_delay_meter #(.LAT_W(8), .SAMPLES_LOG(3), .SYNC_STAGES(SYNC), .PATH_INVERTS(0)) u_dut (
        .clk(clk), .rstN(rstN), .start(start), .pathInput(pathInput), .pathResult(pathResult),
        .busy(busy), .done(done), .timeout(timeout), .total(total), .average(average)
`ifdef SPY_DELAY_MINMAX_EN
        , .minLat(min_lat), .maxLat(max_lat)
`endif
    );

    spy_path_delay_meter #(.LAT_W(8), .SAMPLES_LOG(3), .SYNC_STAGES(SYNC), .PATH_INVERTS(1)) u_inv (
        .clk(clk), .rstN(rstN), .start(start_inv), .pathInput(pin_inv), .pathResult(res_inv),
        .busy(busy_inv), .done(done_inv), .timeout(to_inv), .total(tot_inv), .average(avg_inv)
`ifdef SPY_DELAY_MINMAX_EN
        , .minLat(min_inv), .maxLat(max_inv)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (pathInput !== last_pi) chg_cnt = 0;
        else if (chg_cnt < 100000) chg_cnt = chg_cnt + 1;
        last_pi = pathInput;
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (done) done_cnt = done_cnt + 1;
        if (pathInput !== mon_pi) begin
            tog_cnt    = tog_cnt + 1;
            tog_gap    = cyc - last_tog_t;
            last_tog_t = cyc;
        end
        mon_pi = pathInput;
    end

    task automatic chk(input string nm, input int act, input int exp);
        vec_cnt = vec_cnt + 1;
        if (act != exp) begin
            err_cnt = err_cnt + 1;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Specification-level model: each launch toggles the level, a sample is SYNC+1+delay,
    // and a sample above the 8-bit limit aborts the run with the partial sum kept.
    task automatic model(input int dr, input int df, input logic lvl_in,
                         output int tot, output int to, output logic lvl_out,
                         output int tog, output int mn, output int mx);
        int s;
        tot = 0; to = 0; tog = 0; mn = 255; mx = 0; lvl_out = lvl_in;
        for (int i = 0; i < 8; i++) begin
            lvl_out = ~lvl_out;
            tog = tog + 1;
            s = SYNC + 1 + (lvl_out ? dr : df);
            if (s > 255) begin
                to = 1;
                break;
            end
            tot = tot + s;
            if (s < mn) mn = s;
            if (s > mx) mx = s;
        end
    endtask

    task automatic measure(input bit hold);
        int n;
        @(negedge clk);
        start = 1'b1;
        if (!hold) begin
            @(negedge clk);
            start = 1'b0;
        end
        n = 0;
        while (!done && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", int'(done), 1);
        start = 1'b0;
        @(negedge clk);
        chk("busy_after_done", int'(busy), 0);
    endtask

    typedef struct {
        int dr; int df; bit stuck;
        int tot; int avg; int to; int pin; int tog; int gap; int mn; int mx;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int   tog0, done0, n;
        int   e_tot, e_to, e_tog, e_mn, e_mx;
        logic lvl, lvl_n;

        tbl[0] = '{0,   0,   1'b0, 24,   3,   0, 0, 8, 4,   3,   3};
        tbl[1] = '{5,   5,   1'b0, 64,   8,   0, 0, 8, 9,   8,   8};
        tbl[2] = '{2,   6,   1'b0, 56,   7,   0, 0, 8, 6,   5,   9};
        tbl[3] = '{252, 252, 1'b0, 2040, 255, 0, 0, 8, 256, 255, 255};
        tbl[4] = '{0,   0,   1'b1, 0,    0,   1, 1, 1, -1,  255, 0};
        tbl[5] = '{0,   0,   1'b0, 24,   3,   0, 1, 8, 4,   3,   3};
        tbl[6] = '{253, 0,   1'b0, 3,    0,   1, 1, 2, -1,  3,   3};

        rstN = 1'b1; start = 1'b0; start_inv = 1'b0;
        #1 rstN = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pathInput", int'(pathInput), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_total", int'(total), 0);
        chk("rst_average", int'(average), 0);
`ifdef SPY_DELAY_MINMAX_EN
        chk("rst_minLat", int'(min_lat), 255);
        chk("rst_maxLat", int'(max_lat), 0);
`endif
        rstN = 1'b1;
        repeat (2) @(negedge clk);

        // Table of directed measurements; each row starts from the level the previous row left.
        for (int v = 0; v < 7; v++) begin
            d_rise = tbl[v].dr; d_fall = tbl[v].df; stuck0 = tbl[v].stuck;
            tog0 = tog_cnt; done0 = done_cnt;
            measure(1'b0);
            chk($sformatf("v%0d_total", v), int'(total), tbl[v].tot);
            chk($sformatf("v%0d_average", v), int'(average), tbl[v].avg);
            chk($sformatf("v%0d_timeout", v), int'(timeout), tbl[v].to);
            chk($sformatf("v%0d_pathInput", v), int'(pathInput), tbl[v].pin);
            chk($sformatf("v%0d_toggles", v), tog_cnt - tog0, tbl[v].tog);
            chk($sformatf("v%0d_done_pulses", v), done_cnt - done0, 1);
            if (tbl[v].gap >= 0) chk($sformatf("v%0d_last_gap", v), tog_gap, tbl[v].gap);
`ifdef SPY_DELAY_MINMAX_EN
            chk($sformatf("v%0d_minLat", v), int'(min_lat), tbl[v].mn);
            chk($sformatf("v%0d_maxLat", v), int'(max_lat), tbl[v].mx);
`endif
            stuck0 = 1'b0;
            repeat (3) @(negedge clk);
        end

        // Randomized delays against the model; occasionally long enough to time out.
        lvl = 1'b1;
        for (int it = 0; it < 6; it++) begin
            d_rise = ($urandom_range(0, 7) == 0) ? int'($urandom_range(250, 256)) : int'($urandom_range(0, 30));
            d_fall = ($urandom_range(0, 7) == 0) ? int'($urandom_range(250, 256)) : int'($urandom_range(0, 30));
            model(d_rise, d_fall, lvl, e_tot, e_to, lvl_n, e_tog, e_mn, e_mx);
            tog0 = tog_cnt;
            measure(1'b0);
            chk($sformatf("r%0d_total", it), int'(total), e_tot);
            chk($sformatf("r%0d_average", it), int'(average), e_tot >> 3);
            chk($sformatf("r%0d_timeout", it), int'(timeout), e_to);
            chk($sformatf("r%0d_pathInput", it), int'(pathInput), int'(lvl_n));
            chk($sformatf("r%0d_toggles", it), tog_cnt - tog0, e_tog);
`ifdef SPY_DELAY_MINMAX_EN
            chk($sformatf("r%0d_minLat", it), int'(min_lat), e_mn);
            chk($sformatf("r%0d_maxLat", it), int'(max_lat), e_mx);
`endif
            lvl = lvl_n;
            repeat (4) @(negedge clk);
        end

        // Asynchronous reset during the fourth sample's wait.
        d_rise = 0; d_fall = 0;
        tog0 = tog_cnt; done0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while ((tog_cnt - tog0) < 4 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reached_4th", tog_cnt - tog0, 4);
        chk("mid_partial_total", int'(total), 9);
        chk("mid_busy", int'(busy), 1);
        rstN = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_total", int'(total), 0);
        chk("mid_rst_pathInput", int'(pathInput), 0);
        @(negedge clk);
        rstN = 1'b1;
        repeat (5) @(negedge clk);
        chk("mid_no_done", done_cnt - done0, 0);
        measure(1'b0);
        chk("post_rst_total", int'(total), 24);
        chk("post_rst_timeout", int'(timeout), 0);

        // start held high up to and including the done cycle: one measurement only.
        done0 = done_cnt;
        measure(1'b1);
        chk("hold_total", int'(total), 24);
        repeat (300) @(negedge clk);
        chk("hold_done_pulses", done_cnt - done0, 1);
        chk("hold_busy_idle", int'(busy), 0);

        // Inverting chain on the second instance.
        @(negedge clk);
        start_inv = 1'b1;
        @(negedge clk);
        start_inv = 1'b0;
        n = 0;
        while (!done_inv && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("inv_done_seen", int'(done_inv), 1);
        chk("inv_total", int'(tot_inv), 24);
        chk("inv_average", int'(avg_inv), 3);
        chk("inv_timeout", int'(to_inv), 0);
        chk("inv_pathInput", int'(pin_inv), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
